// File: rtl/nand_op_sequencer.sv
// rtl/nand_op_sequencer.sv - turns page-level READ/PROGRAM/ERASE/RESET requests into cpu_if transactions
// PROGRAM and ERASE are followed by a READ STATUS transaction whose bit0 decides pass/fail.
module nand_op_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CMND_WIDTH     = 16,
  parameter int BYTE_PER_PAGE  = 2048,
  parameter int SPARE_BYTES    = 64,
  parameter int PAGE_PER_BLOCK = 64,
  parameter int BLOCK_SIZE     = 2048,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              op_valid,
  output logic                              op_ready,
  input  logic [1:0]                        op_code,
  input  logic [$clog2(BLOCK_SIZE)-1:0]     op_block,
  input  logic [$clog2(PAGE_PER_BLOCK)-1:0] op_page,
  input  logic [11:0]                       op_column,
  input  logic [11:0]                       op_length,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [1:0]                        rsp_status,
  output logic [CMND_WIDTH-1:0]             cpu_if_command,
  output logic                              cpu_if_command_valid,
  output logic [ADDR_WIDTH-1:0]             cpu_if_address,
  output logic [ADDR_WIDTH/8-1:0]           cpu_if_address_bytes,
  output logic [ADDR_WIDTH-1:0]             cpu_if_data_bytes,
  output logic                              cpu_if_data_rw,
  output logic                              cpu_if_data_wp,
  output logic                              cpu_if_access_request,
  input  logic                              cpu_if_access_complete,
  input  logic                              cpu_if_access_ready,
  input  logic                              status_valid,
  input  logic [7:0]                        status_data
);
  localparam int BW = $clog2(BLOCK_SIZE);
  localparam int PW = $clog2(PAGE_PER_BLOCK);
  localparam int RW = BW + PW;
  localparam int AB = ADDR_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [12:0]   PAGE_LIMIT = 13'(BYTE_PER_PAGE + SPARE_BYTES);

  localparam logic [1:0] OP_READ = 2'd0, OP_PROGRAM = 2'd1, OP_ERASE = 2'd2;
  localparam logic [1:0] ST_OK = 2'd0, ST_FAIL = 2'd1, ST_TIMEOUT = 2'd2, ST_BADARG = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_STAT_ISSUE, S_STAT_WAIT, S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      code_q;
  logic [BW-1:0]   block_q;
  logic [PW-1:0]   page_q;
  logic [11:0]     column_q, length_q;
  logic [1:0]      rsp_nx;
  logic [TW-1:0]   tcnt;
  logic            got_byte;
  logic [7:0]      byte_q;
  logic [RW-1:0]   row;
  logic            modifies, bad_arg, timed_out, stat_fail;

  assign row       = RW'(block_q) * RW'(PAGE_PER_BLOCK) + RW'(page_q);
  assign modifies  = (code_q == OP_PROGRAM) || (code_q == OP_ERASE);
  assign timed_out = (tcnt == T_LAST);
  assign bad_arg   = (((code_q == OP_READ) || (code_q == OP_PROGRAM)) &&
                      ((length_q == 12'd0) || (({1'b0, column_q} + {1'b0, length_q}) > PAGE_LIMIT))) ||
                     ((code_q == OP_ERASE) && (page_q != '0));
  // A byte arriving in the completing cycle still counts as the first status byte.
  assign stat_fail = got_byte ? byte_q[0] : (status_valid ? status_data[0] : 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rsp_nx   = rsp_status;
    case (state)
      S_IDLE:  if (op_valid) state_nx = S_CHECK;
      S_CHECK: begin
        if (bad_arg) begin
          state_nx = S_RESP;
          rsp_nx   = ST_BADARG;
        end else begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: if (cpu_if_access_ready) state_nx = S_WAIT;
      S_WAIT: begin
        if (cpu_if_access_complete) begin
          if (modifies) begin
            state_nx = S_STAT_ISSUE;
          end else begin
            state_nx = S_RESP;
            rsp_nx   = ST_OK;
          end
        end else if (timed_out) begin
          state_nx = S_RESP;
          rsp_nx   = ST_TIMEOUT;
        end
      end
      S_STAT_ISSUE: if (cpu_if_access_ready) state_nx = S_STAT_WAIT;
      S_STAT_WAIT: begin
        if (cpu_if_access_complete) begin
          state_nx = S_RESP;
          rsp_nx   = stat_fail ? ST_FAIL : ST_OK;
        end else if (timed_out) begin
          state_nx = S_RESP;
          rsp_nx   = ST_TIMEOUT;
        end
      end
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready              = (state == S_IDLE);
    rsp_valid             = (state == S_RESP);
    cpu_if_access_request = (state == S_WAIT) || (state == S_STAT_WAIT);
    cpu_if_data_wp        = !(modifies && ((state == S_ISSUE) || (state == S_WAIT) ||
                                           (state == S_STAT_ISSUE) || (state == S_STAT_WAIT)));
    cpu_if_command        = '0;
    cpu_if_command_valid  = 1'b0;
    cpu_if_address        = '0;
    cpu_if_address_bytes  = '0;
    cpu_if_data_bytes     = '0;
    cpu_if_data_rw        = 1'b0;
    if ((state == S_ISSUE) || (state == S_WAIT)) begin
      case (code_q)
        2'd0: begin
          cpu_if_command       = CMND_WIDTH'(16'h3000);
          cpu_if_command_valid = 1'b1;
          cpu_if_address       = ADDR_WIDTH'({row, column_q});
          cpu_if_address_bytes = AB'(5);
          cpu_if_data_bytes    = ADDR_WIDTH'(length_q);
          cpu_if_data_rw       = 1'b1;
        end
        2'd1: begin
          cpu_if_command       = CMND_WIDTH'(16'h1080);
          cpu_if_command_valid = 1'b1;
          cpu_if_address       = ADDR_WIDTH'({row, column_q});
          cpu_if_address_bytes = AB'(5);
          cpu_if_data_bytes    = ADDR_WIDTH'(length_q);
        end
        2'd2: begin
          cpu_if_command       = CMND_WIDTH'(16'hD060);
          cpu_if_command_valid = 1'b1;
          cpu_if_address       = ADDR_WIDTH'({row, 12'd0});
          cpu_if_address_bytes = AB'(3);
        end
        default: cpu_if_command = CMND_WIDTH'(16'h00FF);
      endcase
    end else if ((state == S_STAT_ISSUE) || (state == S_STAT_WAIT)) begin
      cpu_if_command    = CMND_WIDTH'(16'h0070);
      cpu_if_data_bytes = ADDR_WIDTH'(1);
      cpu_if_data_rw    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q     <= '0;
      block_q    <= '0;
      page_q     <= '0;
      column_q   <= '0;
      length_q   <= '0;
      rsp_status <= ST_OK;
      tcnt       <= '0;
      got_byte   <= 1'b0;
      byte_q     <= '0;
    end else begin
      rsp_status <= rsp_nx;
      if ((state == S_IDLE) && op_valid) begin
        code_q   <= op_code;
        block_q  <= op_block;
        page_q   <= op_page;
        column_q <= op_column;
        length_q <= op_length;
      end
      if ((state == S_ISSUE) || (state == S_STAT_ISSUE)) tcnt <= '0;
      else if ((state == S_WAIT) || (state == S_STAT_WAIT)) tcnt <= tcnt + TW'(1);
      if (state == S_STAT_ISSUE) begin
        got_byte <= 1'b0;
      end else if ((state == S_STAT_WAIT) && status_valid && !got_byte) begin
        got_byte <= 1'b1;
        byte_q   <= status_data;
      end
    end
  end
endmodule
